rpll_fsp_switch_ctrl: RTL and testbench

//  Sequences the rPLL state machine (rpll_sm) through frequency set-point (FSP) changes.
//  - Holds rpll_sm in reset and loads the selected FSP config word onto pll_cfg.
//  - Releases reset, asserts enable, then waits for lock with a timeout.
//  - Retries on timeout or loss of lock.
//  - Reports to the requester over a 4-phase req/ack handshake.

---
 rtl/rpll_fsp_switch_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_rpll_fsp_switch_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpll_fsp_switch_ctrl.sv
// rPLL frequency set-point switch controller: walks rpll_sm through reset-hold, enable and
// lock for each FSP change, retries failed locks and answers the requester on a 4-phase req/ack.
module rpll_fsp_switch_ctrl #(
  parameter int unsigned  NUM_FSP = 2,
  parameter int unsigned  CFG_W   = 32,
  parameter int unsigned  TO_W    = 16,
  localparam int unsigned FSP_W   = (NUM_FSP > 1) ? $clog2(NUM_FSP) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_FSP*CFG_W-1:0] swi_fsp_cfg,
  input  logic [7:0]               swi_rst_hold,
  input  logic [TO_W-1:0]          swi_lock_timeout,
  input  logic [3:0]               swi_max_retries,
  input  logic                     fsw_req,
  input  logic [FSP_W-1:0]         fsw_fsp,
  output logic                     fsw_ack,
  output logic                     fsw_err,
  input  logic                     pll_ready,
  input  logic                     pll_loss_of_lock,
  output logic                     pll_sm_reset,
  output logic                     pll_sm_enable,
  output logic [CFG_W-1:0]         pll_cfg,
  output logic [FSP_W-1:0]         cur_fsp,
  output logic [3:0]               retry_cnt,
  output logic [2:0]               fsm_state
);

  // Wide enough for both the reset-hold length and the lock timeout.
  localparam int unsigned CNT_W = (TO_W > 8) ? TO_W : 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StHold   = 3'd1,
    StEnable = 3'd2,
    StLocked = 3'd3,
    StError  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FSP_W-1:0]   tgt_q, tgt_d;
  logic [FSP_W-1:0]   cur_fsp_q, cur_fsp_d;
  logic [3:0]         retry_q, retry_d;
  logic               pending_q, pending_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               sm_reset_q, sm_reset_d;
  logic               sm_enable_q, sm_enable_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;

  logic [CFG_W-1:0]   cfg_words [NUM_FSP];
  logic [CNT_W-1:0]   cnt_inc;
  logic [3:0]         max_eff;
  logic               retry_ok;
  logic               timeout_en;
  logic               req_live;
  logic               accept;
  logic               fsp_invalid;
  logic               fail;
  logic               enter_hold;

  for (genvar g = 0; g < NUM_FSP; g++) begin : g_cfg
    assign cfg_words[g] = swi_fsp_cfg[g*CFG_W +: CFG_W];
  end

  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign max_eff     = (swi_max_retries == 4'd0) ? 4'd1 : swi_max_retries;
  assign retry_ok    = ({1'b0, retry_q} + 5'd1) < {1'b0, max_eff};
  assign timeout_en  = (swi_lock_timeout != '0);
  assign fsp_invalid = (32'(fsw_fsp) >= NUM_FSP);
  // The requester only gets an answer if it is still asking when the attempt ends.
  assign req_live    = pending_q & fsw_req;
  // Loss of lock takes precedence; a request seen in that cycle is taken after relock/error.
  assign accept      = fsw_req & ~ack_q &
                       ((state_q == StIdle) || (state_q == StError) ||
                        ((state_q == StLocked) && !pll_loss_of_lock));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tgt_d       = tgt_q;
    cur_fsp_d   = cur_fsp_q;
    retry_d     = retry_q;
    pending_d   = pending_q;
    ack_d       = ack_q;
    err_d       = err_q;
    sm_reset_d  = sm_reset_q;
    sm_enable_d = sm_enable_q;
    cfg_d       = cfg_q;
    fail        = 1'b0;
    enter_hold  = 1'b0;

    if (!fsw_req) begin
      pending_d = 1'b0;
      ack_d     = 1'b0;
      err_d     = 1'b0;
    end

    unique case (state_q)
      StHold: begin
        if (cnt_q == CNT_W'(swi_rst_hold)) begin
          state_d     = StEnable;
          cnt_d       = '0;
          sm_reset_d  = 1'b0;
          sm_enable_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StEnable: begin
        if (pll_ready) begin
          state_d   = StLocked;
          cur_fsp_d = tgt_q;
          retry_d   = '0;
          pending_d = 1'b0;
          if (req_live) begin
            ack_d = 1'b1;
            err_d = 1'b0;
          end
        end else if (timeout_en && (cnt_q == CNT_W'(swi_lock_timeout))) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StLocked: fail = pll_loss_of_lock;
      default: ;
    endcase

    if (fail) begin
      if (retry_ok) begin
        retry_d    = retry_q + 4'd1;
        enter_hold = 1'b1;
      end else begin
        state_d     = StError;
        retry_d     = max_eff;
        sm_reset_d  = 1'b1;
        sm_enable_d = 1'b0;
        pending_d   = 1'b0;
        if (req_live) begin
          ack_d = 1'b1;
          err_d = 1'b1;
        end
      end
    end

    if (accept) begin
      retry_d = '0;
      if (fsp_invalid) begin
        ack_d = 1'b1;
        err_d = 1'b1;
      end else begin
        tgt_d = fsw_fsp;
        if ((state_q == StLocked) && (fsw_fsp == cur_fsp_q)) begin
          ack_d = 1'b1;
          err_d = 1'b0;
        end else begin
          pending_d  = 1'b1;
          enter_hold = 1'b1;
        end
      end
    end

    if (enter_hold) begin
      state_d     = StHold;
      cnt_d       = '0;
      sm_reset_d  = 1'b1;
      sm_enable_d = 1'b0;
      cfg_d       = cfg_words[tgt_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      tgt_q       <= '0;
      cur_fsp_q   <= '0;
      retry_q     <= '0;
      pending_q   <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      sm_reset_q  <= 1'b1;
      sm_enable_q <= 1'b0;
      cfg_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tgt_q       <= tgt_d;
      cur_fsp_q   <= cur_fsp_d;
      retry_q     <= retry_d;
      pending_q   <= pending_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      sm_reset_q  <= sm_reset_d;
      sm_enable_q <= sm_enable_d;
      cfg_q       <= cfg_d;
    end
  end

  assign fsw_ack       = ack_q;
  assign fsw_err       = err_q;
  assign pll_sm_reset  = sm_reset_q;
  assign pll_sm_enable = sm_enable_q;
  assign pll_cfg       = cfg_q;
  assign cur_fsp       = cur_fsp_q;
  assign retry_cnt     = retry_q;
  assign fsm_state     = state_q;

endmodule

// File: tb/tb_rpll_fsp_switch_ctrl.sv
// Bench for rpll_fsp_switch_ctrl: table of switch transactions, hand sequences for relock,
// abandoned requests and async reset, then random transactions against an arithmetic model.
module tb_rpll_fsp_switch_ctrl;
  localparam int unsigned NumFsp = 3;
  localparam int unsigned CfgW   = 32;
  localparam int unsigned ToW    = 16;

  typedef struct {
    int fsp; int hold; int to; int maxr; int k; int d;
    int lat; int err; int retry; int cur; int st; int cfg_idx;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NumFsp*CfgW-1:0] swi_fsp_cfg;
  logic [7:0]             swi_rst_hold;
  logic [ToW-1:0]         swi_lock_timeout;
  logic [3:0]             swi_max_retries;
  logic                   fsw_req;
  logic [1:0]             fsw_fsp;
  logic                   fsw_ack;
  logic                   fsw_err;
  logic                   pll_ready;
  logic                   pll_loss_of_lock;
  logic                   pll_sm_reset;
  logic                   pll_sm_enable;
  logic [CfgW-1:0]        pll_cfg;
  logic [1:0]             cur_fsp;
  logic [3:0]             retry_cnt;
  logic [2:0]             fsm_state;

  logic [CfgW-1:0] cfg_w [NumFsp];
  int   checks = 0;
  int   errors = 0;
  int   rsp_k, rsp_d, rsp_attempt, rsp_age;
  logic rsp_prev_en;
  bit   ack_seen;
  int   m_state, m_cur;
  logic [31:0] m_cfg;

  always #5 clk = ~clk;

  rpll_fsp_switch_ctrl #(
    .NUM_FSP (NumFsp),
    .CFG_W   (CfgW),
    .TO_W    (ToW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .swi_fsp_cfg      (swi_fsp_cfg),
    .swi_rst_hold     (swi_rst_hold),
    .swi_lock_timeout (swi_lock_timeout),
    .swi_max_retries  (swi_max_retries),
    .fsw_req          (fsw_req),
    .fsw_fsp          (fsw_fsp),
    .fsw_ack          (fsw_ack),
    .fsw_err          (fsw_err),
    .pll_ready        (pll_ready),
    .pll_loss_of_lock (pll_loss_of_lock),
    .pll_sm_reset     (pll_sm_reset),
    .pll_sm_enable    (pll_sm_enable),
    .pll_cfg          (pll_cfg),
    .cur_fsp          (cur_fsp),
    .retry_cnt        (retry_cnt),
    .fsm_state        (fsm_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // rpll_sm stand-in: pulses ready on cycle d of the (k+1)-th enable window.
  task automatic arm_responder(input int k, input int d);
    rsp_k       = k;
    rsp_d       = d;
    rsp_attempt = 0;
    rsp_age     = 0;
    rsp_prev_en = pll_sm_enable;
    pll_ready   = 1'b0;
    ack_seen    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (fsw_ack) ack_seen = 1'b1;
    if (pll_sm_enable && !rsp_prev_en) begin
      rsp_attempt++;
      rsp_age = 0;
    end else if (pll_sm_enable) begin
      rsp_age++;
    end
    rsp_prev_en = pll_sm_enable;
    pll_ready   = pll_sm_enable && (rsp_attempt == rsp_k + 1) && (rsp_age == rsp_d);
  endtask

  task automatic check_outputs(input string name, input int err, input int retry,
                               input int cur, input int st, input logic [31:0] cfg);
    chk({name, " err"},    32'(fsw_err),       err);
    chk({name, " retry"},  32'(retry_cnt),     retry);
    chk({name, " cur"},    32'(cur_fsp),       cur);
    chk({name, " state"},  32'(fsm_state),     st);
    chk({name, " cfg"},    pll_cfg,            cfg);
    chk({name, " reset"},  32'(pll_sm_reset),  (st == 3) ? 0 : 1);
    chk({name, " enable"}, 32'(pll_sm_enable), (st == 3) ? 1 : 0);
  endtask

  task automatic run_txn(input string name, input int fsp, input int hold, input int to,
                         input int maxr, input int k, input int d, input int lat,
                         input int err, input int retry, input int cur, input int st,
                         input logic [31:0] cfg);
    int n = 0;
    swi_rst_hold     = 8'(hold);
    swi_lock_timeout = 16'(to);
    swi_max_retries  = 4'(maxr);
    arm_responder(k, d);
    fsw_fsp = 2'(fsp);
    fsw_req = 1'b1;
    do begin
      step();
      n++;
    end while (!fsw_ack && n < 400);
    chk({name, " latency"}, 32'(n), lat);
    check_outputs(name, err, retry, cur, st, cfg);
    fsw_req = 1'b0;
    step();
    chk({name, " ack release"}, 32'(fsw_ack), 0);
    chk({name, " err release"}, 32'(fsw_err), 0);
  endtask

  // Transaction-level prediction: each lock attempt costs (hold+1) + (timeout+1) cycles.
  task automatic predict(input int fsp, input int hold, input int to, input int maxr,
                         input int k, input int d, output int lat, output int err,
                         output int retry);
    int maxe  = (maxr == 0) ? 1 : maxr;
    int round = (hold + 1) + (to + 1);
    retry = 0;
    if (fsp >= NumFsp) begin
      lat = 1;
      err = 1;
    end else if (m_state == 3 && fsp == m_cur) begin
      lat = 1;
      err = 0;
    end else if (k < maxe) begin
      lat     = k * round + (hold + 1) + d + 2;
      err     = 0;
      m_state = 3;
      m_cur   = fsp;
      m_cfg   = cfg_w[fsp];
    end else begin
      lat     = maxe * round + 1;
      err     = 1;
      retry   = maxe;
      m_state = 4;
      m_cfg   = cfg_w[fsp];
    end
  endtask

  initial begin
    vec_t tbl [8];
    int   n;
    tbl[0] = '{1, 3, 0,  3, 0, 20, 26, 0, 0, 1, 3, 1};
    tbl[1] = '{2, 3, 10, 3, 3, 0,  46, 1, 3, 1, 4, 2};
    tbl[2] = '{3, 3, 10, 3, 0, 0,  1,  1, 0, 1, 4, 2};
    tbl[3] = '{0, 0, 5,  0, 0, 5,  8,  0, 0, 0, 3, 0};
    tbl[4] = '{0, 0, 5,  0, 0, 0,  1,  0, 0, 0, 3, 0};
    tbl[5] = '{2, 2, 3,  0, 1, 0,  8,  1, 1, 0, 4, 2};
    tbl[6] = '{1, 1, 2,  4, 2, 0,  14, 0, 0, 1, 3, 1};
    tbl[7] = '{3, 1, 2,  4, 0, 0,  1,  1, 0, 1, 3, 1};

    cfg_w[0] = 32'hA5A5_0000;
    cfg_w[1] = 32'hBEEF_0001;
    cfg_w[2] = 32'hC0FF_EE02;
    swi_fsp_cfg      = {cfg_w[2], cfg_w[1], cfg_w[0]};
    swi_rst_hold     = 8'd3;
    swi_lock_timeout = 16'd0;
    swi_max_retries  = 4'd3;
    fsw_req          = 1'b0;
    fsw_fsp          = 2'd0;
    pll_ready        = 1'b0;
    pll_loss_of_lock = 1'b0;
    reset            = 1'b1;
    arm_responder(99, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step();
    chk("reset ack", 32'(fsw_ack), 0);
    check_outputs("reset", 0, 0, 0, 0, 32'h0);

    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i].fsp, tbl[i].hold, tbl[i].to, tbl[i].maxr,
              tbl[i].k, tbl[i].d, tbl[i].lat, tbl[i].err, tbl[i].retry, tbl[i].cur,
              tbl[i].st, cfg_w[tbl[i].cfg_idx]);
    end

    // Loss of lock while LOCKED on fsp1: autonomous relock, no ack.
    arm_responder(0, 0);
    pll_loss_of_lock = 1'b1;
    step();
    pll_loss_of_lock = 1'b0;
    n = 1;
    chk("lol hold state", 32'(fsm_state), 1);
    chk("lol hold reset", 32'(pll_sm_reset), 1);
    chk("lol retry", 32'(retry_cnt), 1);
    while (fsm_state != 3'd3 && n < 50) begin
      step();
      n++;
    end
    chk("lol relock cycles", 32'(n), 4);
    check_outputs("lol relock", 0, 0, 1, 3, cfg_w[1]);
    chk("lol no ack", 32'(ack_seen), 0);

    // Request withdrawn during HOLD: switch still completes, ack suppressed.
    arm_responder(0, 1);
    fsw_fsp = 2'd2;
    fsw_req = 1'b1;
    step();
    fsw_req = 1'b0;
    n = 1;
    while (fsm_state != 3'd3 && n < 50) begin
      step();
      n++;
    end
    chk("drop lock cycles", 32'(n), 5);
    check_outputs("drop", 0, 0, 2, 3, cfg_w[2]);
    chk("drop no ack", 32'(ack_seen), 0);

    // Asynchronous reset in the middle of ENABLE.
    swi_lock_timeout = 16'd0;
    arm_responder(99, 0);
    fsw_fsp = 2'd0;
    fsw_req = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (fsm_state != 3'd2 && n < 50);
    chk("rst reach enable", 32'(fsm_state), 2);
    #2 reset = 1'b1;
    #1;
    chk("rst ack", 32'(fsw_ack), 0);
    check_outputs("rst async", 0, 0, 0, 0, 32'h0);
    fsw_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step();
    m_state = 0;
    m_cur   = 0;
    m_cfg   = 32'h0;

    for (int i = 0; i < 40; i++) begin
      int fsp, hold, to, maxr, maxe, k, d, lat, err, retry;
      fsp  = int'($urandom_range(3, 0));
      hold = int'($urandom_range(4, 0));
      to   = int'($urandom_range(6, 1));
      maxr = int'($urandom_range(4, 0));
      maxe = (maxr == 0) ? 1 : maxr;
      k    = int'($urandom_range(maxe, 0));
      d    = int'($urandom_range(to, 0));
      predict(fsp, hold, to, maxr, k, d, lat, err, retry);
      run_txn($sformatf("rnd%0d", i), fsp, hold, to, maxr, k, d, lat, err, retry,
              m_cur, m_state, m_cfg);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
